// File: rtl/demux4_stream.sv
// rtl/demux4_stream.sv - 1-to-4 stream demultiplexer with one holding register per channel
// Optional per-channel delivered-word counters: define DEMUX4_STREAM_CNT_EN.
module demux4_stream #(
    parameter int WIDTH = 2,
    parameter int CNT_W = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [1:0]           in_sel_i,
    input  logic [WIDTH-1:0]     in_data_i,
    output logic [3:0]           out_valid_o,
    input  logic [3:0]           out_ready_i,
    output logic [4*WIDTH-1:0]   out_data_o,
    output logic [4*CNT_W-1:0]   out_cnt_o
);

    logic [3:0]            full_q, full_d;
    logic [3:0][WIDTH-1:0] buf_q, buf_d;
    logic [3:0]            deliver;
    logic                  accept;

    // A full channel can still take a word in the same cycle its consumer drains it.
    assign in_ready_o = ~full_q[in_sel_i] | out_ready_i[in_sel_i];
    assign accept     = in_valid_i & in_ready_o;
    assign deliver    = full_q & out_ready_i;

    always_comb begin
        full_d = full_q;
        buf_d  = buf_q;
        for (int i = 0; i < 4; i++) begin
            if (deliver[i]) begin
                full_d[i] = 1'b0;
            end
            if (accept && (in_sel_i == 2'(i))) begin
                full_d[i] = 1'b1;
                buf_d[i]  = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_q <= '0;
            buf_q  <= '0;
        end else begin
            full_q <= full_d;
            buf_q  <= buf_d;
        end
    end

    assign out_valid_o = full_q;
    assign out_data_o  = buf_q;

`ifdef DEMUX4_STREAM_CNT_EN
    logic [3:0][CNT_W-1:0] cnt_q, cnt_d;

    // Counters stick at all-ones instead of wrapping.
    always_comb begin
        cnt_d = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (deliver[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_cnt_o = cnt_q;
`else
    assign out_cnt_o = '0;
`endif

endmodule

// File: tb/tb_demux4_stream.sv
// tb/tb_demux4_stream.sv - scoreboard bench for demux4_stream
module tb_demux4_stream;

    localparam int WIDTH = 2;
    localparam int CNT_W = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [1:0]           in_sel = 2'd0;
    logic [WIDTH-1:0]     in_data = '0;
    logic [3:0]           out_valid;
    logic [3:0]           out_ready = 4'b0000;
    logic [4*WIDTH-1:0]   out_data;
    logic [4*CNT_W-1:0]   out_cnt;

    int vectors = 0;
    int miscompares = 0;

    logic [WIDTH-1:0] sb_q[4][$];

    demux4_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_sel_i    (in_sel),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_data_o  (out_data),
        .out_cnt_o   (out_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard: sample handshakes mid-cycle, pop on delivery, push on acceptance.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (out_valid[i] && out_ready[i]) begin
                    vectors++;
                    if (sb_q[i].size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_unexpected ch%0d: got %b, expected no word", i, out_data[i*WIDTH +: WIDTH]);
                    end else begin
                        logic [WIDTH-1:0] exp;
                        exp = sb_q[i].pop_front();
                        if (out_data[i*WIDTH +: WIDTH] !== exp) begin
                            miscompares++;
                            $display("FAIL sb_data ch%0d: got %b, expected %b", i, out_data[i*WIDTH +: WIDTH], exp);
                        end
                    end
                end
            end
            if (in_valid && in_ready) sb_q[in_sel].push_back(in_data);
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 4'b0000;
        repeat (2) next();
        vectors++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1 || out_data !== '0 || out_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset: got valid=%b ready=%b data=%b cnt=%b, expected 0000 1 0 0",
                     out_valid, in_ready, out_data, out_cnt);
        end
        rst_n = 1'b1;
        next();
        vectors++;
        if (out_valid !== 4'b0000 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release: got valid=%b ready=%b, expected 0000 1", out_valid, in_ready);
        end
    endtask

    task automatic test_routing();
        logic [1:0] pat [4];
        pat = '{2'b01, 2'b10, 2'b11, 2'b00};
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = pat[k];
            next();
        end
        in_sel  = 2'd2;
        in_data = 2'b01;
        #1;
        vectors++;
        if (out_valid !== 4'b1111 || out_data !== 8'b00_11_10_01 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL routing: got valid=%b data=%b ready=%b, expected 1111 00111001 0",
                     out_valid, out_data, in_ready);
        end
        next();
        vectors++;
        if (out_valid !== 4'b1111 || out_data !== 8'b00_11_10_01 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL routing_pending: got valid=%b data=%b ready=%b, expected 1111 00111001 0",
                     out_valid, out_data, in_ready);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_stall_isolation();
        out_ready = 4'b1000;
        next();
        out_ready = 4'b0000;
        vectors++;
        if (out_valid !== 4'b0111) begin
            miscompares++;
            $display("FAIL stall_drain3: got valid=%b, expected 0111", out_valid);
        end
        in_valid = 1'b1;
        in_sel   = 2'd1;
        in_data  = 2'b11;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_blocked: got in_ready=%b, expected 0", in_ready);
        end
        in_sel  = 2'd3;
        in_data = 2'b01;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL stall_other_ready: got in_ready=%b, expected 1", in_ready);
        end
        next();
        in_valid = 1'b0;
        vectors++;
        if (out_valid !== 4'b1111 || out_data[7:6] !== 2'b01 || out_data[3:2] !== 2'b10) begin
            miscompares++;
            $display("FAIL stall_isolation: got valid=%b data=%b, expected 1111 01xx10xx", out_valid, out_data);
        end
        out_ready = 4'b1111;
        next();
        out_ready = 4'b0000;
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL drain_all: got valid=%b, expected 0000", out_valid);
        end
    endtask

    task automatic test_pass_through();
        out_ready = 4'b1111;
        for (int d = 0; d < 4; d++) begin
            in_valid = 1'b1;
            in_sel   = 2'd2;
            in_data  = 2'(d);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL pass_ready word%0d: got %b, expected 1", d, in_ready);
            end
            next();
            vectors++;
            if (out_valid[2] !== 1'b1 || out_data[5:4] !== 2'(d)) begin
                miscompares++;
                $display("FAIL pass_out word%0d: got valid=%b data=%b, expected 1 %b",
                         d, out_valid[2], out_data[5:4], 2'(d));
            end
        end
        in_valid = 1'b0;
        next();
        vectors++;
        if (out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL pass_end: got valid=%b, expected 0000", out_valid);
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_async_reset();
        out_ready = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            in_sel   = 2'(k);
            in_data  = 2'(3 - k);
            next();
        end
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 4'b0000 || out_data !== '0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b data=%b ready=%b, expected 0000 0 1",
                     out_valid, out_data, in_ready);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 4'b1111;
        repeat (2) begin
            next();
            vectors++;
            if (out_valid !== 4'b0000) begin
                miscompares++;
                $display("FAIL async_reset_stale: got valid=%b, expected 0000", out_valid);
            end
        end
        out_ready = 4'b0000;
    endtask

    task automatic test_cnt();
        logic [CNT_W-1:0] exp;
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        out_ready = 4'b0001;
        for (int k = 0; k < 6; k++) begin
            in_valid = (k < 5);
            in_sel   = 2'd0;
            in_data  = 2'(k);
            next();
            if (k >= 1) begin
`ifdef DEMUX4_STREAM_CNT_EN
                exp = (k > 3) ? CNT_W'(3) : CNT_W'(k);
`else
                exp = '0;
`endif
                vectors++;
                if (out_cnt[CNT_W-1:0] !== exp || out_cnt[4*CNT_W-1:CNT_W] !== '0) begin
                    miscompares++;
                    $display("FAIL cnt step%0d: got %b, expected slice0=%b others 0", k, out_cnt, exp);
                end
            end
        end
        in_valid = 1'b0;
        out_ready = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_routing();
        test_stall_isolation();
        test_pass_through();
        test_async_reset();
        test_cnt();
        next();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (sb_q[i].size() != 0) begin
                miscompares++;
                $display("FAIL sb_leftover ch%0d: got %0d pending words, expected 0", i, sb_q[i].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
